// File: rtl/obc_bin_sequencer_pkg.sv
// Shared types, constants and sign-extension helper for the OBC bin sequencer.
// Defining OBC_OFFSET_EN adds the StOffs state to the state enum.
package obc_pkg;

    localparam int unsigned OBC_NPTS  = 16;
    localparam int unsigned OBC_ROM_W = 32;
    localparam int unsigned OBC_EXT_W = 64;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
`ifdef OBC_OFFSET_EN
        StOffs,
`endif
        StDone
    } obc_seq_state_t;

    // Widest supported accumulator is OBC_EXT_W; callers truncate to their width.
    function automatic logic [OBC_EXT_W-1:0] obc_sext(input logic [OBC_ROM_W-1:0] v);
        return {{(OBC_EXT_W - OBC_ROM_W){v[OBC_ROM_W-1]}}, v};
    endfunction

endpackage

// File: rtl/obc_bin_sequencer_if.sv
// Frame-in / bin-out valid/ready bundle of the OBC bin sequencer.
// The sequencer uses the slave modport; the frame source and consumer use master.
interface obc_bin_sequencer_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned ACC_W = 40
);
    import obc_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [OBC_NPTS*DW-1:0] in_samples;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;

    modport master (
        output in_valid, in_samples, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_samples, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/obc_bitplane_sel.sv
// Frame register plus bit-plane decoder: presents bit bit_idx_i of every sample,
// flagging the sign plane; outputs are zero whenever en_i is low.
module obc_bitplane_sel
    import obc_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   en_i,
    input  logic [OBC_NPTS*DW-1:0] samples_i,
    input  logic [$clog2(DW)-1:0]  bit_idx_i,
    output logic [OBC_NPTS-1:0]    slice_bits_o,
    output logic                   slice_m_o
);

    localparam int unsigned IdxW = $clog2(DW);

    logic [OBC_NPTS*DW-1:0] frame_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
        end else if (load_i) begin
            frame_q <= samples_i;
        end
    end

    always_comb begin
        logic [DW-1:0] smp;
        slice_bits_o = '0;
        slice_m_o    = 1'b0;
        smp          = '0;
        if (en_i) begin
            for (int k = 0; k < OBC_NPTS; k++) begin
                smp             = frame_q[k*DW +: DW];
                slice_bits_o[k] = smp[bit_idx_i];
            end
            slice_m_o = (bit_idx_i == IdxW'(DW - 1));
        end
    end

endmodule

// File: rtl/obc_bin_sequencer.sv
// Bit-serial sequencer for one 16-point OBC DFT bin; requires 32+DW-1 <= ACC_W <= 64.
// Optional OBC_OFFSET_EN adds an offset_in port and an OFFS state after the planes.
module obc_bin_sequencer
    import obc_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned ACC_W = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    obc_bin_sequencer_if.slave    bus,
    output logic [OBC_NPTS-1:0]   slice_bits,
    output logic                  slice_m,
    input  logic [OBC_ROM_W-1:0]  rom_in,
`ifdef OBC_OFFSET_EN
    input  logic [OBC_ROM_W-1:0]  offset_in,
`endif
    output logic                  busy
);

    localparam int unsigned IdxW   = $clog2(DW);
    localparam logic [IdxW-1:0] IdxMsb = IdxW'(DW - 1);

    obc_seq_state_t   state_q, state_d;
    logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] rom_ext;
    logic             load;
    logic             run;

    assign rom_ext = ACC_W'(obc_sext(rom_in));
    assign run     = (state_q == StRun);

`ifdef OBC_OFFSET_EN
    logic [OBC_ROM_W-1:0] offs_q;
    logic [ACC_W-1:0]     offs_ext;

    assign offs_ext = ACC_W'(obc_sext(offs_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offs_q <= '0;
        end else if (load) begin
            offs_q <= offset_in;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_idx_q <= IdxMsb;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            acc_q     <= acc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        acc_d     = acc_q;
        load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    load      = 1'b1;
                    bit_idx_d = IdxMsb;
                    acc_d     = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                // MSB plane first: each older contribution gains one binary weight.
                acc_d = (acc_q << 1) + rom_ext;
                if (bit_idx_q == '0) begin
                    bit_idx_d = IdxMsb;
`ifdef OBC_OFFSET_EN
                    state_d   = StOffs;
`else
                    state_d   = StDone;
`endif
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end
`ifdef OBC_OFFSET_EN
            StOffs: begin
                acc_d   = acc_q + offs_ext;
                state_d = StDone;
            end
`endif
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    obc_bitplane_sel #(
        .DW (DW)
    ) u_bitplane_sel (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .en_i         (run),
        .samples_i    (bus.in_samples),
        .bit_idx_i    (bit_idx_q),
        .slice_bits_o (slice_bits),
        .slice_m_o    (slice_m)
    );

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = bus.out_valid ? acc_q : '0;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_obc_bin_sequencer.sv
// Self-checking bench for obc_bin_sequencer with a popcount ROM model, so each
// bin result equals the sum of the frame's samples (plus offset when enabled).
`timescale 1ns/1ps
module tb_obc_bin_sequencer;
    import obc_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned ACC_W = 40;
    localparam int unsigned FW    = OBC_NPTS * DW;
`ifdef OBC_OFFSET_EN
    localparam int     Lat  = DW + 1;
    localparam longint Offs = 100;
`else
    localparam int     Lat  = DW;
    localparam longint Offs = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [OBC_NPTS-1:0]   slice_bits;
    logic                  slice_m;
    logic [OBC_ROM_W-1:0]  rom_in;
    logic                  busy;
`ifdef OBC_OFFSET_EN
    logic [OBC_ROM_W-1:0]  offset_in;
`endif

    obc_bin_sequencer_if #(.DW(DW), .ACC_W(ACC_W)) bus ();

    obc_bin_sequencer #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .slice_bits (slice_bits),
        .slice_m    (slice_m),
        .rom_in     (rom_in),
`ifdef OBC_OFFSET_EN
        .offset_in  (offset_in),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ROM model: popcount of the plane, negated on the sign plane.
    always_comb begin
        rom_in = slice_m ? -32'($countones(slice_bits)) : 32'($countones(slice_bits));
    end

    int     n_checks = 0;
    int     n_pass   = 0;
    longint sb[$];

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint frame_sum(input logic [FW-1:0] f);
        longint s = Offs;
        for (int k = 0; k < OBC_NPTS; k++) s += longint'($signed(f[k*DW +: DW]));
        return s;
    endfunction

    function automatic logic [FW-1:0] fill(input logic [DW-1:0] v);
        return {OBC_NPTS{v}};
    endfunction

    function automatic longint sdata();
        return longint'($signed(bus.out_data));
    endfunction

    task automatic run_frame(input logic [FW-1:0] f, input int hold, input string tag);
        int          cyc;
        logic [63:0] m_hist;
        longint      held;
        check({tag, "_in_ready"}, longint'(bus.in_ready), 1);
        bus.in_samples = f;
        bus.in_valid   = 1'b1;
        sb.push_back(frame_sum(f));
        tick();
        bus.in_valid   = 1'b0;
        bus.in_samples = ~f;
        cyc    = 0;
        m_hist = '0;
        while (!bus.out_valid && cyc < 64) begin
            if (slice_m) m_hist[cyc] = 1'b1;
            tick();
            cyc++;
        end
        check({tag, "_latency"}, longint'(cyc), longint'(Lat));
        check({tag, "_slice_m"}, longint'(m_hist), 1);
        held = sdata();
        for (int i = 0; i < hold; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_samples = fill(8'h33);
            tick();
            check({tag, "_hold_valid"}, longint'(bus.out_valid), 1);
            check({tag, "_hold_data"}, sdata(), held);
            check({tag, "_hold_in_ready"}, longint'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        check({tag, "_slice_bits_off"}, longint'(slice_bits), 0);
        bus.out_ready = 1'b1;
        check({tag, "_data"}, sdata(), sb.pop_front());
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_back_idle"}, longint'({bus.in_ready, busy, bus.out_valid}), 4);
    endtask

    initial begin
        int cyc;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_samples = '0;
        bus.out_ready  = 1'b0;
`ifdef OBC_OFFSET_EN
        offset_in      = 32'd100;
`endif
        #12;
        tick();
        rst = 1'b0;
        tick();
        check("reset_in_ready", longint'(bus.in_ready), 1);
        check("reset_out_valid", longint'(bus.out_valid), 0);
        check("reset_out_data", sdata(), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_slice", longint'({slice_bits, slice_m}), 0);

        run_frame(fill(8'h01), 0, "ones");
        run_frame(fill(8'h80), 0, "all_neg");
        run_frame(fill(8'h7F), 0, "all_pos");
        run_frame({(OBC_NPTS/2){16'h807F}}, 0, "alt");
        run_frame(fill(8'h01), 5, "stall");

        // Abort in RUN cycle 3.
        bus.in_samples = fill(8'h55);
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_run_busy", longint'(busy), 0);
        check("abort_run_in_ready", longint'(bus.in_ready), 1);
        check("abort_run_out_valid", longint'(bus.out_valid), 0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_run_release", longint'({bus.in_ready, busy, bus.out_valid}), 4);
        run_frame(fill(8'h01), 0, "after_abort");

        // Abort while the result is waiting in DONE.
        bus.in_samples = fill(8'h11);
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 64) begin
            tick();
            cyc++;
        end
        check("abort_done_reached", longint'(bus.out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_done_out_valid", longint'(bus.out_valid), 0);
        check("abort_done_out_data", sdata(), 0);
        tick();
        rst = 1'b0;
        tick();

        for (int r = 0; r < 3; r++) begin
            logic [FW-1:0] f;
            for (int k = 0; k < OBC_NPTS; k++) f[k*DW +: DW] = DW'($urandom);
            run_frame(f, r, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
